addsub_arb: RTL

ADDSUB_ARB -- requirements
Module: addsub_arb

---
 rtl/addsub_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/addsub_arb.sv
// ---------------------------------------------------------------------------
// addsub_arb
//   Two-requester add/subtract unit with a round-robin arbiter.
//   A request sampled in IDLE is captured; the owner sees a one-cycle grant
//   pulse in EXEC. The result is presented with a one-cycle oVld pulse in
//   DONE, and then the unit returns to IDLE.
//
//   Optional feature: define ADDSUB_ARB_OVF_EN to add the oOvf output.
//   oOvf is the two's-complement signed overflow of the operation.
//
// Ports
//   iClk            clock, rising edge
//   iRstn           asynchronous reset, active low
//   iReq0/iReq1     operation request per requester
//   iOp0/iOp1       0 = add, 1 = subtract
//   iA0,iB0,iA1,iB1 unsigned operands, W bits
//   oGnt0/oGnt1     one-cycle pulse: that requester's operands were captured
//   oVld            one-cycle pulse: oS/oC/oId are valid
//   oId             owner of the current result
//   oS              sum or difference, W bits
//   oC              carry-out on add, borrow on subtract
//   oBusy           high whenever the state is not IDLE
//   oOvf            signed overflow (ADDSUB_ARB_OVF_EN only)
//
// State | meaning
// IDLE  | waiting for a request; arbitrate and capture operands
// EXEC  | grant pulse to the owner; result computed into registers
// DONE  | result valid pulse; results held afterwards until next DONE
// ---------------------------------------------------------------------------
module addsub_arb #(
    parameter int W = 4
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iReq0,
    input  logic         iReq1,
    input  logic         iOp0,
    input  logic         iOp1,
    input  logic [W-1:0] iA0,
    input  logic [W-1:0] iB0,
    input  logic [W-1:0] iA1,
    input  logic [W-1:0] iB1,
    output logic         oGnt0,
    output logic         oGnt1,
    output logic         oVld,
    output logic         oId,
    output logic [W-1:0] oS,
    output logic         oC,
`ifdef ADDSUB_ARB_OVF_EN
    output logic         oOvf,
`endif
    output logic         oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           ptr_q;
    logic           own_q;
    logic           op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           gnt0_q;
    logic           gnt1_q;
    logic           vld_q;
    logic           id_q;
    logic [W-1:0]   s_q;
    logic           c_q;
    logic           busy_q;

    logic           any_req_d;
    logic           sel_d;
    logic [W-1:0]   b_eff_d;
    logic [W:0]     sum_d;
    logic           c_d;

    // Both requesting: the pointer decides; otherwise whoever is asking.
    assign any_req_d = iReq0 | iReq1;
    assign sel_d     = (iReq0 & iReq1) ? ptr_q : iReq1;

    // Subtract as A + ~B + 1; borrow is the inverted carry.
    assign b_eff_d = op_q ? ~b_q : b_q;
    assign sum_d   = {1'b0, a_q} + {1'b0, b_eff_d} + {{W{1'b0}}, op_q};
    assign c_d     = sum_d[W] ^ op_q;

`ifdef ADDSUB_ARB_OVF_EN
    logic ovf_q;
    logic ovf_d;
    // Operands (after B inversion) share a sign but the result sign differs.
    assign ovf_d = (a_q[W-1] == b_eff_d[W-1]) && (sum_d[W-1] != a_q[W-1]);
    assign oOvf  = ovf_q;
`endif

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            own_q   <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            vld_q   <= 1'b0;
            id_q    <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            vld_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        own_q   <= sel_d;
                        op_q    <= sel_d ? iOp1 : iOp0;
                        a_q     <= sel_d ? iA1  : iA0;
                        b_q     <= sel_d ? iB1  : iB0;
                        ptr_q   <= ~sel_d;
                        gnt0_q  <= ~sel_d;
                        gnt1_q  <= sel_d;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    s_q     <= sum_d[W-1:0];
                    c_q     <= c_d;
                    id_q    <= own_q;
`ifdef ADDSUB_ARB_OVF_EN
                    ovf_q   <= ovf_d;
`endif
                    vld_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oGnt0 = gnt0_q;
    assign oGnt1 = gnt1_q;
    assign oVld  = vld_q;
    assign oId   = id_q;
    assign oS    = s_q;
    assign oC    = c_q;
    assign oBusy = busy_q;

endmodule
